// File: rtl/seq_det_pkg.sv
// Shared constants and helpers for the serial pattern detector.
package seq_det_pkg;

  localparam int PAT_W_MAX = 16;
  localparam int CNT_W_MAX = 16;

  localparam logic [3:0] PAT_0110 = 4'b0110;

  // Fill counter must hold the values 0..pat_w inclusive.
  function automatic int fill_w(input int pat_w);
    return $clog2(pat_w + 1);
  endfunction

endpackage

// File: rtl/seq_detector_if.sv
// Stream, pattern-control and result signals of the detector.
interface seq_detector_if #(
  parameter int PAT_W = 4,
  parameter int CNT_W = 8
);
  logic             din_valid;
  logic             din_bit;
  logic             pat_load;
  logic [PAT_W-1:0] pat_in;
  logic             overlap_en;
  logic             cnt_clr;
  logic             detect_out;
  logic [CNT_W-1:0] match_cnt;
  logic             cnt_sat;

  modport master (
    output din_valid, din_bit, pat_load, pat_in, overlap_en, cnt_clr,
    input  detect_out, match_cnt, cnt_sat
  );

  modport slave (
    input  din_valid, din_bit, pat_load, pat_in, overlap_en, cnt_clr,
    output detect_out, match_cnt, cnt_sat
  );
endinterface

// File: rtl/sat_counter.sv
// Saturating up-counter; a clear wins over a simultaneous increment.
module sat_counter #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         clr,
  input  logic         inc,
  output logic [W-1:0] count,
  output logic         sat
);

  logic [W-1:0] count_q, count_d;
  logic         sat_q, sat_d;

  always_comb begin
    count_d = count_q;
    sat_d   = sat_q;
    if (clr) begin
      count_d = '0;
      sat_d   = 1'b0;
    end else if (inc && !sat_q) begin
      count_d = count_q + 1'b1;
      sat_d   = (count_d == '1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count_q <= '0;
      sat_q   <= 1'b0;
    end else begin
      count_q <= count_d;
      sat_q   <= sat_d;
    end
  end

  assign count = count_q;
  assign sat   = sat_q;

endmodule

// File: rtl/seq_detector.sv
// Serial bit-pattern detector with runtime pattern reload, overlap control
// and a saturating match counter.
module seq_detector
  import seq_det_pkg::*;
#(
  parameter int               PAT_W       = 4,
  parameter logic [PAT_W-1:0] DEFAULT_PAT = PAT_0110,
  parameter int               CNT_W       = 8
) (
  input  logic         clk,
  input  logic         rst_n,
  seq_detector_if.slave bus
);

  localparam int               FILL_W   = fill_w(PAT_W);
  localparam logic [FILL_W-1:0] FILL_MAX = FILL_W'(PAT_W);

  logic [PAT_W-1:0]  pat_q, pat_d;
  logic [PAT_W-1:0]  hist_q, hist_d;
  logic [PAT_W-1:0]  hist_shift;
  logic [FILL_W-1:0] fill_q, fill_d;
  logic              det_q, det_d;
  logic              match;
  logic [CNT_W-1:0]  cnt;
  logic              sat;

  assign hist_shift = {hist_q[PAT_W-2:0], bus.din_bit};

  always_comb begin
    pat_d  = pat_q;
    hist_d = hist_q;
    fill_d = fill_q;
    det_d  = 1'b0;
    match  = 1'b0;
    if (bus.pat_load) begin
      pat_d  = bus.pat_in;
      hist_d = '0;
      fill_d = '0;
    end else if (bus.din_valid) begin
      hist_d = hist_shift;
      if (fill_q != FILL_MAX) fill_d = fill_q + 1'b1;
      // fill_q >= PAT_W-1 means this bit completes a fully populated window
      if ((hist_shift == pat_q) && (fill_q >= FILL_MAX - 1'b1)) begin
        match = 1'b1;
        det_d = 1'b1;
        if (!bus.overlap_en) fill_d = '0;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pat_q  <= DEFAULT_PAT;
      hist_q <= '0;
      fill_q <= '0;
      det_q  <= 1'b0;
    end else begin
      pat_q  <= pat_d;
      hist_q <= hist_d;
      fill_q <= fill_d;
      det_q  <= det_d;
    end
  end

  sat_counter #(.W(CNT_W)) u_cnt (
    .clk   (clk),
    .rst_n (rst_n),
    .clr   (bus.cnt_clr),
    .inc   (match),
    .count (cnt),
    .sat   (sat)
  );

  assign bus.detect_out = det_q;
  assign bus.match_cnt  = cnt;
  assign bus.cnt_sat    = sat;

endmodule

// File: tb/tb_seq_detector.sv
// Scoreboard bench: two detectors (8-bit and 2-bit counters) share one stimulus stream.
module tb_seq_detector;
  import seq_det_pkg::*;

  localparam int PAT_W = 4;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  seq_detector_if #(.PAT_W(PAT_W), .CNT_W(8)) bus_a ();
  seq_detector_if #(.PAT_W(PAT_W), .CNT_W(2)) bus_b ();

  seq_detector #(.PAT_W(PAT_W), .DEFAULT_PAT(4'b0110), .CNT_W(8)) dut_a (
    .clk(clk), .rst_n(rst_n), .bus(bus_a));
  seq_detector #(.PAT_W(PAT_W), .DEFAULT_PAT(4'b0110), .CNT_W(2)) dut_b (
    .clk(clk), .rst_n(rst_n), .bus(bus_b));

  typedef struct {
    logic       det;
    logic [7:0] ca;
    logic       sa;
    logic [1:0] cb;
    logic       sb;
  } exp_t;

  exp_t exp_q[$];
  int   total = 0;
  int   bad   = 0;

  // reference model: bits consumed since the last restart, pattern, counts
  bit         m_bits[$];
  logic [3:0] m_pat;
  int         m_cnt_a;
  int         m_cnt_b;
  logic       cur_ovl;

  task automatic chk(input string name, input int act, input int req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s at %0t: got %0d expected %0d", name, $time, act, req);
    end
  endtask

  task automatic model_reset();
    m_bits.delete();
    m_pat   = 4'b0110;
    m_cnt_a = 0;
    m_cnt_b = 0;
  endtask

  task automatic step(input logic v, input logic b, input logic ld = 1'b0,
                      input logic [3:0] p = 4'd0, input logic clr = 1'b0);
    exp_t e;
    bit   hit;
    @(negedge clk);
    bus_a.din_valid = v;  bus_b.din_valid = v;
    bus_a.din_bit   = b;  bus_b.din_bit   = b;
    bus_a.pat_load  = ld; bus_b.pat_load  = ld;
    bus_a.pat_in    = p;  bus_b.pat_in    = p;
    bus_a.cnt_clr   = clr; bus_b.cnt_clr  = clr;
    bus_a.overlap_en = cur_ovl; bus_b.overlap_en = cur_ovl;
    hit = 1'b0;
    if (ld) begin
      m_pat = p;
      m_bits.delete();
    end else if (v) begin
      m_bits.push_back(b);
      if (m_bits.size() > PAT_W) void'(m_bits.pop_front());
      if (m_bits.size() == PAT_W) begin
        hit = 1'b1;
        for (int i = 0; i < PAT_W; i++)
          if (m_bits[i] != m_pat[PAT_W-1-i]) hit = 1'b0;
      end
      if (hit && !cur_ovl) m_bits.delete();
    end
    if (clr) begin
      m_cnt_a = 0;
      m_cnt_b = 0;
    end else if (hit) begin
      if (m_cnt_a < 255) m_cnt_a++;
      if (m_cnt_b < 3)   m_cnt_b++;
    end
    e.det = hit;
    e.ca  = 8'(m_cnt_a);
    e.sa  = (m_cnt_a == 255);
    e.cb  = 2'(m_cnt_b);
    e.sb  = (m_cnt_b == 3);
    exp_q.push_back(e);
  endtask

  task automatic send(input logic [3:0] nib, input int n = 4);
    for (int i = n - 1; i >= 0; i--) step(1'b1, nib[i]);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(1'b0, 1'b0);
  endtask

  task automatic chk_zero(input string tag);
    chk({tag, "_det_a"}, int'(bus_a.detect_out), 0);
    chk({tag, "_cnt_a"}, int'(bus_a.match_cnt), 0);
    chk({tag, "_sat_a"}, int'(bus_a.cnt_sat), 0);
    chk({tag, "_det_b"}, int'(bus_b.detect_out), 0);
    chk({tag, "_cnt_b"}, int'(bus_b.match_cnt), 0);
    chk({tag, "_sat_b"}, int'(bus_b.cnt_sat), 0);
  endtask

  // monitor: one expected response per issued stimulus edge
  always @(posedge clk) begin
    exp_t e;
    #1;
    if (rst_n && exp_q.size() > 0) begin
      e = exp_q.pop_front();
      chk("detect_a", int'(bus_a.detect_out), int'(e.det));
      chk("count_a",  int'(bus_a.match_cnt),  int'(e.ca));
      chk("sat_a",    int'(bus_a.cnt_sat),    int'(e.sa));
      chk("detect_b", int'(bus_b.detect_out), int'(e.det));
      chk("count_b",  int'(bus_b.match_cnt),  int'(e.cb));
      chk("sat_b",    int'(bus_b.cnt_sat),    int'(e.sb));
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    logic [3:0] rp;
    bus_a.din_valid = 0; bus_b.din_valid = 0;
    bus_a.din_bit = 0;   bus_b.din_bit = 0;
    bus_a.pat_load = 0;  bus_b.pat_load = 0;
    bus_a.pat_in = 0;    bus_b.pat_in = 0;
    bus_a.cnt_clr = 0;   bus_b.cnt_clr = 0;
    bus_a.overlap_en = 1; bus_b.overlap_en = 1;
    cur_ovl = 1'b1;
    model_reset();
    #1;
    chk_zero("reset");
    repeat (2) @(posedge clk);
    @(negedge clk) rst_n = 1'b1;
    chk_zero("post_reset");

    // overlapping: 0110110 gives two matches
    send(4'b0110);
    send(3'b110, 3);
    idle(2);

    // non-overlapping, then fresh pattern needed
    cur_ovl = 1'b0;
    step(1'b0, 1'b0, 1'b0, 4'd0, 1'b1);
    send(4'b0110);
    send(3'b110, 3);
    send(4'b0110);
    idle(2);

    // invalid gap with toggling data is transparent
    send(2'b01, 2);
    for (int i = 0; i < 5; i++) step(1'b0, i[0]);
    send(2'b10, 2);
    idle(2);

    // reload mid-pattern; bit on the load edge is discarded
    cur_ovl = 1'b1;
    send(3'b011, 3);
    step(1'b1, 1'b1, 1'b1, 4'b1011);
    send(4'b1011);
    idle(1);
    step(1'b0, 1'b0, 1'b1, 4'b0110);

    // 2-bit counter saturation, then clear on a match edge
    cur_ovl = 1'b0;
    step(1'b0, 1'b0, 1'b0, 4'd0, 1'b1);
    for (int k = 0; k < 5; k++) send(4'b0110);
    send(3'b011, 3);
    step(1'b1, 1'b0, 1'b0, 4'd0, 1'b1);
    idle(2);

    // asynchronous reset mid-pattern
    send(4'b0110);
    send(3'b011, 3);
    idle(1);
    @(negedge clk);
    rst_n = 1'b0;
    bus_a.din_valid = 0; bus_b.din_valid = 0;
    bus_a.pat_load = 0;  bus_b.pat_load = 0;
    bus_a.cnt_clr = 0;   bus_b.cnt_clr = 0;
    model_reset();
    #1;
    chk_zero("midreset");
    repeat (2) @(posedge clk);
    @(negedge clk) rst_n = 1'b1;
    step(1'b1, 1'b0);
    send(4'b0110);
    idle(2);

    // randomized traffic
    for (int n = 0; n < 4000; n++) begin
      if ($urandom_range(0, 63) == 0) cur_ovl = ~cur_ovl;
      rp = 4'($urandom);
      if ($urandom_range(0, 7) == 0) rp = 4'b1111;
      step($urandom_range(0, 3) != 0, 1'($urandom),
           $urandom_range(0, 99) == 0, rp,
           $urandom_range(0, 299) == 0);
    end
    idle(2);

    repeat (3) @(posedge clk);
    #2;
    chk("queue_drained", exp_q.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
